// File: rtl/resv_issue_ctrl_pip1.sv
// Issue control for one pip1 reservation station: picks the oldest ready cell per pipe,
// arbitrates the single removal slot, and tracks occupancy/allocation.
module resv_issue_ctrl_pip1 #(
  parameter int                 N_cell    = 8,
  parameter int                 W_ident   = 4,
  parameter int                 W_pkt     = 139,
  parameter logic [W_ident-1:0] unused_cd = {W_ident{1'b1}}
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic [N_cell*W_ident-1:0] cand0_vec,
  input  logic [N_cell*W_ident-1:0] cand1_vec,
  input  logic [N_cell*W_pkt-1:0]   cell_pkt,
  input  logic                      dp_valid,
  output logic                      dp_ready,
  output logic [W_ident-1:0]        addr_insert,
  output logic [W_ident-1:0]        addr_shift,
  output logic                      x0_valid,
  input  logic                      x0_ready,
  output logic [W_pkt-1:0]          x0_pkt,
  output logic                      x1_valid,
  input  logic                      x1_ready,
  output logic [W_pkt-1:0]          x1_pkt,
  output logic [W_ident-1:0]        occupancy
);

  localparam logic [W_ident-1:0] full_cnt = W_ident'(N_cell);

  logic [W_ident-1:0] occupancy_q, occupancy_d;
  logic               last_grant_q, last_grant_d;
  logic               x0_valid_q, x0_valid_d, x1_valid_q, x1_valid_d;
  logic [W_pkt-1:0]   x0_pkt_q, x0_pkt_d, x1_pkt_q, x1_pkt_d;

  logic [W_ident-1:0] sel0, sel1;
  logic               has0, has1;
  logic [W_pkt-1:0]   pick0, pick1;
  logic               elig0, elig1, gnt0, gnt1, rem, ins;

  // Oldest-first selection; cells at or above the occupancy count may hold stale codes.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel0  = unused_cd;
    sel1  = unused_cd;
    has0  = 1'b0;
    has1  = 1'b0;
    pick0 = '0;
    pick1 = '0;
    for (int k = N_cell - 1; k >= 0; k--) begin
      if (W_ident'(k) < occupancy_q && cand0_vec[k*W_ident +: W_ident] != unused_cd) begin
        sel0  = W_ident'(k);
        has0  = 1'b1;
        pick0 = cell_pkt[k*W_pkt +: W_pkt];
      end
      if (W_ident'(k) < occupancy_q && cand1_vec[k*W_ident +: W_ident] != unused_cd) begin
        sel1  = W_ident'(k);
        has1  = 1'b1;
        pick1 = cell_pkt[k*W_pkt +: W_pkt];
      end
    end
  end

  always_comb begin
    elig0 = !clear && has0 && (!x0_valid_q || x0_ready);
    elig1 = !clear && has1 && (!x1_valid_q || x1_ready);
    // Single shift chain: when both pipes could issue, alternate starting away from the last winner.
    gnt0  = elig0 && (!elig1 || last_grant_q);
    gnt1  = elig1 && (!elig0 || !last_grant_q);
    rem   = gnt0 || gnt1;

    addr_shift = gnt0 ? sel0 : (gnt1 ? sel1 : unused_cd);

    // No bypass of a same-cycle removal into dp_ready, which keeps it off the selection path.
    dp_ready    = !clear && (occupancy_q != full_cnt);
    ins         = dp_valid && dp_ready;
    addr_insert = ins ? (occupancy_q - W_ident'(rem)) : unused_cd;
    occupancy_d = occupancy_q + W_ident'(ins) - W_ident'(rem);

    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;

    x0_valid_d = x0_valid_q;
    x0_pkt_d   = x0_pkt_q;
    if (gnt0) begin
      x0_valid_d = 1'b1;
      x0_pkt_d   = pick0;
    end else if (x0_valid_q && x0_ready) begin
      x0_valid_d = 1'b0;
    end

    x1_valid_d = x1_valid_q;
    x1_pkt_d   = x1_pkt_q;
    if (gnt1) begin
      x1_valid_d = 1'b1;
      x1_pkt_d   = pick1;
    end else if (x1_valid_q && x1_ready) begin
      x1_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (clear) begin
      occupancy_q  <= '0;
      last_grant_q <= 1'b1;
      x0_valid_q   <= 1'b0;
      x1_valid_q   <= 1'b0;
      x0_pkt_q     <= '0;
      x1_pkt_q     <= '0;
    end else begin
      occupancy_q  <= occupancy_d;
      last_grant_q <= last_grant_d;
      x0_valid_q   <= x0_valid_d;
      x1_valid_q   <= x1_valid_d;
      x0_pkt_q     <= x0_pkt_d;
      x1_pkt_q     <= x1_pkt_d;
    end
  end

  assign x0_valid  = x0_valid_q;
  assign x1_valid  = x1_valid_q;
  assign x0_pkt    = x0_pkt_q;
  assign x1_pkt    = x1_pkt_q;
  assign occupancy = occupancy_q;

endmodule

// File: doc/resv_issue_ctrl_pip1.md
Name: resv_issue_ctrl_pip1

Overview:
- Control and issue stage for one 8-cell pip1 reservation station. Consumes each cell's pip0/pip1 candidate codes and payload, and picks the oldest ready entry.
- Latches the picked entry into a per-pipe issue register with a valid/ready handshake toward the pipe0/pip1 execution units.
- Drives the station's addr_shift (remove) and addr_insert (allocate) busses and tracks occupancy. Throttles the decoder via dp_ready.

Parameters:
- N_cell, 8, number of cells in the station; cell idents are 0..N_cell-1, and lower ident means older.
- W_ident, 4, ident/code width.
- unused_cd, {W_ident{1'b1}}, "no cell" code.
- W_pkt, 139, issue payload width: uops(6) + rd_a(5) + rs_d(32) + rt_d(32) + imm_d(32) + pc_d(32), MSB to LSB.

Ports:
- clk  in  1  clock
- clear  in  1  reset; synchronous, active-high
- cand0_vec  in  N_cell*W_ident  candit0 of cell k at bits [k*W_ident +: W_ident]
- cand1_vec  in  N_cell*W_ident  candit1 of cell k, same packing
- cell_pkt  in  N_cell*W_pkt  payload of cell k at bits [k*W_pkt +: W_pkt]
- dp_valid  in  1  decoder offers an instruction (i0_* lines go straight to the cells)
- dp_ready  out  1  station can accept an instruction this cycle
- addr_insert  out  W_ident  cell that captures i0 this edge, else unused_cd
- addr_shift  out  W_ident  removed cell (cells >= it shift down), else unused_cd
- x0_valid  out  1  pipe0 issue register valid
- x0_ready  in  1  pipe0 accepts
- x0_pkt  out  W_pkt  pipe0 payload
- x1_valid  out  1  pipe1 issue register valid
- x1_ready  in  1  pipe1 accepts
- x1_pkt  out  W_pkt  pipe1 payload
- occupancy  out  W_ident  number of valid entries, 0..N_cell

Behaviour:
- Reset (clear=1 at posedge): occupancy=0, x0_valid=x1_valid=0, x0_pkt=x1_pkt=0, last_grant=1.
  - Combinationally while clear=1: dp_ready=0, addr_insert=addr_shift=unused_cd.
  - The cells are cleared by the same clear. Clear mid-transfer drops held packets with no handshake.
- Selection (combinational): selp = lowest k with cand_p[k] != unused_cd; hasp = such a k exists.
- Pipe p is free when !xp_valid || xp_ready.
- Eligibility: eligp = hasp && pipe p free.
- Removal limit: at most one removal per cycle, because there is a single shift chain.
- Arbitration:
  - Only elig0 set: grant pipe0.
  - Only elig1 set: grant pipe1.
  - Both set: grant pipe !last_grant.
  - last_grant updates to the granted pipe on every grant.
- On grant to pipe g:
  - addr_shift = selg.
  - xg_pkt <= cell_pkt[selg]; xg_valid <= 1 at the edge.
- Non-granted pipe p: if xp_valid && xp_ready, then xp_valid <= 0; otherwise hold xp_valid and xp_pkt.
- Throughput: back-to-back issue on the same pipe when xp_ready stays 1 is one packet per cycle, with no bubble.
- No grant: addr_shift = unused_cd. Since unused_cd > every ident, no cell shifts.
- Dispatch readiness: dp_ready = (occupancy != N_cell); it does not depend on same-cycle removal (no bypass). ins = dp_valid && dp_ready.
- Insert position:
  - addr_insert = occupancy - rem when ins, else unused_cd.
  - With simultaneous remove, the new entry lands at occupancy-1, above the compacted entries.
- Occupancy update: occupancy <= occupancy + ins - rem. Full-with-remove stays full-1 for one cycle, then dp_ready=1.
- Latency:
  - An entry inserted at edge t can be a candidate at earliest t+1, can be granted at t+1, and shows xp_valid at edge t+2.
  - Operand wakeup is handled inside the cells.
- Robustness: candidate codes from cells >= occupancy are ignored (masked) to guard against stale data.

Test Plan:
- After clear, 3 dispatches back-to-back -> addr_insert 0,1,2; occupancy 3; addr_shift=1111 throughout.
- Cells 1 and 2 pip0-ready, x0_ready=1 -> cycle A: addr_shift=1, x0_pkt=cell1 payload; cycle B: addr_shift=1 (old cell2 moved to 1), occupancy 3→1.
- Cell0 pip0-ready and cell3 pip1-ready, both pipes free, last_grant=1 -> pipe0 granted (addr_shift=0); next cycle pipe1 granted (addr_shift=2, post-shift position).
- x1_valid=1, x1_ready=0, only pip1 candidates -> no grant, addr_shift=1111, x1_pkt stable; raise x1_ready -> same-cycle new grant, x1_valid stays 1.
- Occupancy 8 with dp_valid=1 -> dp_ready=0, addr_insert=1111. Remove cell 4 -> occupancy 7, then insert at addr_insert=7.
- Occupancy 5, insert + remove cell 2 in the same cycle -> addr_insert=4, addr_shift=2, occupancy stays 5. Assert clear with x0_valid=1 -> x0_valid=0, occupancy=0 next cycle.
